pwm_multi: RTL and testbench
============================

# pwm_multi

Parametrised multi-channel PWM generator that replaces the fixed 16-channel, 8-bit PWM peripheral in the top-level wrapper. Channel count and duty resolution are configurable, and each channel has its own duty register. Duty updates are double-buffered so a new duty only takes effect at a period boundary, which keeps outputs glitch-free. A programmable prescaler sets the PWM frequency. The block sits between the SPI peripheral's register-write stream and the `{uio_out, uo_out}` pins.

## Interface
Parameters:
- `CHANNELS`, 16: number of PWM outputs; 1..32.
- `WIDTH`, 8: duty and counter width; period is `MAX = 2^WIDTH - 1` ticks.
- `PRESC_W`, 8: prescaler register width.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_valid` input 1: register write strobe; one write per cycle; no backpressure.
- `wr_sel` input 2: target register: 0 = DUTY, 1 = EN_OUT, 2 = EN_PWM, 3 = PRESC.
- `wr_chan` input `$clog2(CHANNELS)` (min 1): channel index; DUTY only.
- `wr_data` input 32: write data.
  - DUTY uses `[WIDTH-1:0]`.
  - EN_OUT and EN_PWM use `[CHANNELS-1:0]`.
  - PRESC uses `[PRESC_W-1:0]`.
- `out` output `CHANNELS`: registered channel outputs.
- `period_start` output 1: one-cycle pulse on the cycle after the PWM counter wraps to 0.

## Operation
- State:
  - `shadow_duty[CHANNELS]` and `active_duty[CHANNELS]`, each WIDTH bits.
  - `en_out` and `en_pwm`, each CHANNELS bits.
  - `presc`, PRESC_W bits.
  - `presc_cnt`, PRESC_W bits.
  - `cnt`, WIDTH bits.
- Reset: every register above is 0, `out = 0` and `period_start = 0`.
- Prescaler:
  - `tick` is asserted when `presc_cnt == presc`; on that cycle `presc_cnt` is cleared, otherwise it increments.
  - With `presc = 0`, `tick` is asserted every cycle.
- Counter:
  - On `tick`, `cnt` increments.
  - On `tick` with `cnt == MAX-1`, `cnt` wraps to 0 instead (boundary).
  - Counter range is 0..MAX-1.
- Boundary: `active_duty[i]` loads `shadow_duty[i]` for all channels.
- Write-forward: a DUTY write to channel i in the boundary cycle loads `wr_data` into both `shadow_duty[i]` and `active_duty[i]`.
- Compare: `pwm[i] = (cnt < active_duty[i])`.
  - Duty 0: output constantly low.
  - Duty MAX: output constantly high (100%).
- Output: `out[i] <= en_out[i] ? (en_pwm[i] ? pwm[i] : 1) : 0`.
- Write effects:
  - DUTY writes only `shadow_duty`.
  - EN_OUT and EN_PWM writes replace the whole mask immediately.
  - PRESC writes load `presc` and clear `presc_cnt`; `cnt` is not touched.
- Ignored writes:
  - A DUTY write with `wr_chan >= CHANNELS` is dropped.
  - Mask bits at or above `CHANNELS` are ignored.
- `rst` is allowed mid-period. It overrides any write issued in the same cycle and returns the block to the reset state on the next edge.

## Timing
- Write accepted at edge E.
- Mask changes are visible on `out` after edge E+1.
- A DUTY write becomes visible on `out` one edge after the next boundary edge.
- PWM period is `MAX × (presc+1)` clk cycles.
- High time is `duty × (presc+1)` cycles, measured from the first `out` rise after `period_start`.
- `period_start` is registered: it is high for exactly one cycle following the boundary edge, and is aligned with the first `out` sample of the new period.
- After `rst` deasserts:
  - The first tick occurs on the first cycle (`presc = 0`).
  - The first boundary occurs MAX cycles later.

## Structure
- Package `pwm_multi_pkg` holds:
  - the `wr_sel` encodings (`SEL_DUTY`, `SEL_EN_OUT`, `SEL_EN_PWM`, `SEL_PRESC`);
  - a typedef for the 2-bit select.
- Sub-module `pwm_prescaler` contains `presc`, `presc_cnt` and the tick generation, plus its load/clear input.
- Channel logic is a generate loop inside `pwm_multi`.

## Test plan
Bench settings: `CHANNELS = 4`, `WIDTH = 8` (MAX = 255).

1. Reset then no writes -> `out = 0` and `period_start` never asserts out of phase; it pulses every 255 cycles.
2. Write EN_OUT = 1, EN_PWM = 1 and DUTY[0] = 128, with `presc = 0` -> from the second `period_start` on, `out[0]` is high for 128 cycles and low for 127 of every 255.
3. Write DUTY[1] = 0 and DUTY[2] = 255, with all enables set -> `out[1]` is constantly 0 and `out[2]` is constantly 1 across 3 periods.
4. Write EN_OUT = 0xF, EN_PWM = 0x0 -> all outputs are 1 one edge after the write.
   - Then write EN_OUT = 0x0 -> all outputs are 0 one edge later.
5. Write DUTY[0] = 64 mid-period while the active duty is 200 -> the current period keeps 200 high cycles and the next period has 64.
   - Repeat with the write landing exactly on the boundary cycle -> the next period uses 64.
6. Write PRESC = 3 with DUTY[3] = 10 -> period is 1020 cycles with 40 high.
   - Assert `rst` mid-period -> `out = 0` next edge, and all registers read back as reset on resumption.

Source files
------------

// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: shared definitions for the multi-channel PWM block.
//   wr_sel_e   - register-select encoding carried on wr_sel
//   chan_w()   - width of the channel-index field (never below 1)
package pwm_multi_pkg;

  typedef enum logic [1:0] {
    SEL_DUTY   = 2'd0,
    SEL_EN_OUT = 2'd1,
    SEL_EN_PWM = 2'd2,
    SEL_PRESC  = 2'd3
  } wr_sel_e;

  // A single-channel build still needs a 1-bit index port.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: programmable clock divider producing the PWM counter tick.
//   clk, rst  - clock, synchronous active-high reset
//   load      - load presc from load_val and restart the divider count
//   load_val  - new prescaler value
//   tick      - high on cycles where the divider count matches presc
//               (every cycle when presc = 0)
module pwm_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PRESC_W-1:0] load_val,
  output logic               tick
);

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_cnt;

  // Combinational so the counter advances in the same cycle the match occurs.
  assign tick = (presc_cnt == presc);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      presc_cnt <= '0;
    end else if (load) begin
      presc     <= load_val;
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: parametrised multi-channel PWM generator with double-buffered
// duty registers and a shared programmable prescaler.
//   clk, rst      - clock, synchronous active-high reset
//   wr_valid      - register write strobe (one per cycle, no backpressure)
//   wr_sel        - 0 DUTY, 1 EN_OUT, 2 EN_PWM, 3 PRESC
//   wr_chan       - channel index for DUTY writes (out-of-range dropped)
//   wr_data       - write data
//   out           - registered channel outputs
//   period_start  - one-cycle pulse aligned with the first output sample
//                   of each new PWM period
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int WIDTH    = 8,
  parameter int PRESC_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [1:0]                    wr_sel,
  input  logic [chan_w(CHANNELS)-1:0]   wr_chan,
  input  logic [31:0]                   wr_data,
  output logic [CHANNELS-1:0]           out,
  output logic                          period_start
);

  localparam int CW = chan_w(CHANNELS);
  // Last counter value before wrap: MAX-1 = 2^WIDTH - 2.
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  logic                wr_duty, presc_load;
  logic                tick, boundary;
  logic [WIDTH-1:0]    cnt;
  logic [CHANNELS-1:0] en_out, en_pwm, pwm;
  // Boundary delay line: stage 0 lines up with the first new-period compare,
  // stage 1 with the registered output of that compare.
  logic [1:0]          bnd_pipe;

  assign wr_duty    = wr_valid && (wr_sel == SEL_DUTY) && (32'(wr_chan) < CHANNELS);
  assign presc_load = wr_valid && (wr_sel == SEL_PRESC);
  assign boundary   = tick && (cnt == CNT_LAST);

  // Sink for write-data bits that no register consumes at this parameter set.
  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data;

  pwm_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .load     (presc_load),
    .load_val (wr_data[PRESC_W-1:0]),
    .tick     (tick)
  );

  // Period counter 0..MAX-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= boundary ? '0 : cnt + WIDTH'(1);
    end
  end

  // Enable masks take effect immediately; bits above CHANNELS are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_out <= '0;
      en_pwm <= '0;
    end else if (wr_valid) begin
      if (wr_sel == SEL_EN_OUT) en_out <= wr_data[CHANNELS-1:0];
      if (wr_sel == SEL_EN_PWM) en_pwm <= wr_data[CHANNELS-1:0];
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [WIDTH-1:0] shadow_duty;
    logic [WIDTH-1:0] active_duty;
    logic             wr_hit;

    assign wr_hit = wr_duty && (wr_chan == CW'(i));

    // Double buffer: active only changes at the wrap. A write landing on the
    // wrap cycle itself is forwarded so it is not lost for a whole period.
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_duty <= '0;
        active_duty <= '0;
      end else begin
        if (wr_hit) shadow_duty <= wr_data[WIDTH-1:0];
        if (boundary) active_duty <= wr_hit ? wr_data[WIDTH-1:0] : shadow_duty;
      end
    end

    // cnt never reaches MAX, so duty MAX yields a solid high.
    assign pwm[i] = (cnt < active_duty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= '0;
      bnd_pipe <= '0;
    end else begin
      out      <= en_out & (~en_pwm | pwm);
      bnd_pipe <= {bnd_pipe[0], boundary};
    end
  end

  assign period_start = bnd_pipe[1];

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;
  import pwm_multi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_sel = 2'd0;
  logic [1:0]  wr_chan = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic [3:0]  out;
  logic        period_start;

  always #5 clk = ~clk;

  pwm_multi #(.CHANNELS(4), .WIDTH(8), .PRESC_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_sel       (wr_sel),
    .wr_chan      (wr_chan),
    .wr_data      (wr_data),
    .out          (out),
    .period_start (period_start)
  );

  int checks = 0;
  int failures = 0;
  int hi[4];
  int fl[4];
  int plen;
  int n;

  typedef struct {
    logic [31:0] eo;
    logic [31:0] ep;
    logic [3:0]  exp_out;
  } mvec_t;
  mvec_t tbl[8];

  task automatic chk(input string name, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp_v);
    end
  endtask

  // Drive one write at a negedge; it is accepted at the following posedge.
  task automatic wr(input logic [1:0] sel, input int ch, input logic [31:0] d);
    wr_valid = 1'b1; wr_sel = sel; wr_chan = 2'(ch); wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_ps(input int maxc, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!period_start && cnt < maxc);
    if (!period_start) begin
      checks++; failures++;
      $display("FAIL wait_ps timeout after %0d cycles", cnt);
    end
  endtask

  // Entered at a negedge with period_start high; samples one full period and
  // returns at the next period_start. Optionally issues one write at sample wk.
  task automatic measure(input int wk, input logic [1:0] sel, input int ch, input logic [31:0] d);
    for (int c = 0; c < 4; c++) begin hi[c] = 0; fl[c] = -1; end
    plen = 0;
    do begin
      for (int c = 0; c < 4; c++) begin
        if (out[c]) hi[c]++;
        else if (fl[c] < 0) fl[c] = plen;
      end
      if (plen == wk) begin
        wr_valid = 1'b1; wr_sel = sel; wr_chan = 2'(ch); wr_data = d;
      end else begin
        wr_valid = 1'b0;
      end
      plen++;
      @(negedge clk);
    end while (!period_start && plen < 5000);
    wr_valid = 1'b0;
    if (!period_start) begin
      checks++; failures++;
      $display("FAIL measure timeout len=%0d", plen);
    end
  endtask

  initial begin
    // ch0 duty 128 (varies), ch1 duty 0, ch2/ch3 duty 255 while this runs
    tbl[0] = '{32'h0F, 32'h00, 4'hF};
    tbl[1] = '{32'h00, 32'h0F, 4'h0};
    tbl[2] = '{32'h0F, 32'h0E, 4'hD};
    tbl[3] = '{32'h06, 32'h06, 4'h4};
    tbl[4] = '{32'h09, 32'h08, 4'h9};
    tbl[5] = '{32'h05, 32'h00, 4'h5};
    tbl[6] = '{32'hF0, 32'h00, 4'h0};
    tbl[7] = '{32'h1F, 32'h1E, 4'hD};

    // 1: reset state and idle period timing
    repeat (3) @(negedge clk);
    chk("rst_out", int'(out), 0);
    chk("rst_ps", int'(period_start), 0);
    rst = 1'b0;
    wait_ps(400, n);
    chk("first_ps_delay", n, 256);
    measure(-1, SEL_DUTY, 0, 0);
    chk("idle_period_len", plen, 255);
    chk("idle_out_high", hi[0] + hi[1] + hi[2] + hi[3], 0);

    // 2/3: duty 128 / 0 / 255 with PWM enabled
    wr(SEL_DUTY, 0, 128);
    wr(SEL_DUTY, 1, 0);
    wr(SEL_DUTY, 2, 255);
    wr(SEL_DUTY, 3, 255);
    wr(SEL_EN_OUT, 0, 32'hF);
    wr(SEL_EN_PWM, 0, 32'hF);
    wait_ps(600, n);
    wait_ps(600, n);
    for (int p = 0; p < 3; p++) begin
      measure(-1, SEL_DUTY, 0, 0);
      chk("d128_len", plen, 255);
      chk("d128_high", hi[0], 128);
      chk("d128_first_low", fl[0], 128);
      chk("d0_high", hi[1], 0);
      chk("d255_high", hi[2], 255);
    end

    // 4: mask vectors, visible one edge after the last mask write
    for (int t = 0; t < 8; t++) begin
      wr(SEL_EN_OUT, 0, tbl[t].eo);
      wr(SEL_EN_PWM, 0, tbl[t].ep);
      @(negedge clk);
      chk($sformatf("mask_vec%0d", t), int'(out), int'(tbl[t].exp_out));
    end

    // 5: double buffering and boundary-cycle forward
    wr(SEL_EN_OUT, 0, 32'hF);
    wr(SEL_EN_PWM, 0, 32'hF);
    wr(SEL_DUTY, 0, 200);
    wait_ps(600, n);
    wait_ps(600, n);
    measure(100, SEL_DUTY, 0, 64);
    chk("mid_write_cur_period", hi[0], 200);
    chk("mid_write_len", plen, 255);
    measure(100, SEL_DUTY, 0, 200);
    chk("mid_write_next_period", hi[0], 64);
    measure(253, SEL_DUTY, 0, 64);   // sample 253 is the wrap cycle
    chk("bnd_write_cur_period", hi[0], 200);
    measure(-1, SEL_DUTY, 0, 0);
    chk("bnd_write_next_period", hi[0], 64);
    chk("bnd_write_len", plen, 255);

    // 6: prescaler 3
    wr(SEL_PRESC, 0, 3);
    wr(SEL_DUTY, 3, 10);
    wait_ps(3000, n);
    wait_ps(3000, n);
    measure(-1, SEL_DUTY, 0, 0);
    chk("presc_len", plen, 1020);
    chk("presc_d10_high", hi[3], 40);
    chk("presc_d10_first_low", fl[3], 40);
    chk("presc_d64_high", hi[0], 256);
    chk("presc_d0_high", hi[1], 0);
    chk("presc_d255_high", hi[2], 1020);

    // mid-period reset, with a competing mask write in the same cycle
    repeat (100) @(negedge clk);
    rst = 1'b1;
    wr_valid = 1'b1; wr_sel = SEL_EN_OUT; wr_chan = 2'd0; wr_data = 32'hF;
    @(negedge clk);
    chk("midrst_out", int'(out), 0);
    chk("midrst_ps", int'(period_start), 0);
    rst = 1'b0;
    wr_valid = 1'b0;
    wait_ps(400, n);
    chk("postrst_ps_delay", n, 256);
    chk("postrst_out", int'(out), 0);
    wr(SEL_EN_OUT, 0, 32'hF);
    wr(SEL_EN_PWM, 0, 32'hF);
    wait_ps(400, n);
    measure(-1, SEL_DUTY, 0, 0);
    chk("postrst_len", plen, 255);
    chk("postrst_duty_zero", hi[0] + hi[1] + hi[2] + hi[3], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
